fifo_buf: RTL and testbench

Single-clock 8-bit FIFO buffer: dual-port storage array, write/read pointer blocks with full/empty generation, and an optional pointer-synchronizer stage. It sits between a producer and a consumer in the same clock domain. It is the verification vehicle for the storage, read-pointer and pointer-sync logic later reused in the dual-clock FIFO.

---
 rtl/fifo_buf_pkg.sv | 13 +
 rtl/fifo_buf_ptr_sync.sv | 21 ++
 rtl/fifo_buf.sv | 64 ++++++
 tb/tb_fifo_buf.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fifo_buf_pkg.sv
// Shared widths, pointer type and Gray-code helper for fifo_buf.
package fifo_buf_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int PTR_W      = DEF_ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Width-agnostic helper; callers cast to their own pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/fifo_buf_ptr_sync.sv
// Two-stage pointer synchronizer, asynchronous active-low reset to 0.
module ptr_sync #(
    parameter int W = fifo_buf_pkg::PTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/fifo_buf.sv
// Single-clock FIFO with binary pointers and wrap bit.
// FIFO_PTR_SYNC_EN: compare Gray pointers through 2-flop synchronizers.
module fifo_buf
    import fifo_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     waddr, raddr;
    logic              wacc, racc;

    assign wacc = wen && !full;
    assign racc = ren && !empty;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wacc) mem[waddr[ADDR_W-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr <= '0;
            raddr <= '0;
            rdata <= '0;
        end else begin
            if (wacc) waddr <= waddr + 1'b1;
            if (racc) begin
                raddr <= raddr + 1'b1;
                rdata <= mem[raddr[ADDR_W-1:0]];
            end
        end
    end

`ifdef FIFO_PTR_SYNC_EN
    logic [PW-1:0] wgray, rgray, wsync, rsync;

    assign wgray = PW'(bin2gray(32'(waddr)));
    assign rgray = PW'(bin2gray(32'(raddr)));

    ptr_sync #(.W(PW)) u_wsync (.clk(clk), .reset(reset), .d(wgray), .q(wsync));
    ptr_sync #(.W(PW)) u_rsync (.clk(clk), .reset(reset), .d(rgray), .q(rsync));

    // Gray full: top two bits inverted, remainder equal.
    assign empty = (rgray == wsync);
    assign full  = (wgray == {~rsync[PW-1:PW-2], rsync[PW-3:0]});
`else
    assign empty = (raddr == waddr);
    assign full  = (waddr[ADDR_W-1:0] == raddr[ADDR_W-1:0]) &&
                   (waddr[ADDR_W] != raddr[ADDR_W]);
`endif
endmodule

// File: tb/tb_fifo_buf.sv
// Randomized self-checking bench for fifo_buf against a queue model.
module tb_fifo_buf;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wen = 1'b0;
    logic [7:0] wdata = '0;
    logic       ren = 1'b0;
    logic [7:0] rdata;
    logic       full, empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_rd = 8'h00;

    fifo_buf dut (
        .clk(clk), .reset(reset), .wen(wen), .wdata(wdata),
        .ren(ren), .rdata(rdata), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(model_q.size() == 16));
        chk({tag, ".rdata"}, 32'(rdata), 32'(exp_rd));
    endtask

    // One cycle: check current outputs, drive, then advance the model at the edge.
    task automatic step(input string tag, input logic w, input logic [7:0] wd, input logic r);
        bit wa, ra;
        @(negedge clk);
        check_state(tag);
        wen = w; wdata = wd; ren = r;
        wa = w && (model_q.size() < 16);
        ra = r && (model_q.size() > 0);
        @(posedge clk);
        if (ra) exp_rd = model_q.pop_front();
        if (wa) model_q.push_back(wd);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full",  32'(full),  32'd0);
        chk("rst.rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Read while empty is ignored
        step("rd_empty", 1'b0, 8'h00, 1'b1);
        idle("rd_empty_post");

        // Fill to full, reject 17th, drain in order
        for (int i = 1; i <= 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
        step("fill17", 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1);
        idle("drain_done");
        chk("drain_last", 32'(rdata), 32'h10);

        // Move pointers then cross the wrap boundary
        for (int i = 0; i < 10; i++) step("f10", 1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 10; i++) step("d10", 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step("wrap_w", 1'b1, 8'(8'h20 + i), 1'b0);
            if (i % 3 == 2) step("wrap_r", 1'b0, 8'h00, 1'b1);
        end
        while (model_q.size() > 0) step("wrap_rd", 1'b0, 8'h00, 1'b1);
        idle("wrap_end");
        chk("wrap_last", 32'(rdata), 32'h33);

        // Concurrent read/write at occupancy 5
        for (int i = 0; i < 5; i++) step("occ5", 1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("both", 1'b1, 8'(8'h70 + i), 1'b1);
            chk("occ_hold", 32'(model_q.size()), 32'd5);
        end
        while (model_q.size() > 0) step("occ_rd", 1'b0, 8'h00, 1'b1);

        // Simultaneous write+read on empty: write only
        step("sim_empty", 1'b1, 8'hA5, 1'b1);
        idle("sim_post");
        step("sim_rd", 1'b0, 8'h00, 1'b1);
        idle("sim_rd_post");
        chk("sim_data", 32'(rdata), 32'hA5);

        // Simultaneous write+read when full: read only
        for (int i = 0; i < 16; i++) step("f2", 1'b1, 8'(8'h80 + i), 1'b0);
        step("sim_full", 1'b1, 8'hEE, 1'b1);
        chk("sim_full_occ", 32'(model_q.size()), 32'd15);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) step("burst", 1'b1, 8'(8'h90 + i), 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.empty", 32'(empty), 32'd1);
        chk("arst.full",  32'(full),  32'd0);
        chk("arst.rdata", 32'(rdata), 32'd0);
        model_q.delete();
        exp_rd = 8'h00;
        wen = 1'b0; ren = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step("post_w", 1'b1, 8'hC3, 1'b0);
        step("post_w", 1'b1, 8'hC4, 1'b0);
        step("post_r", 1'b0, 8'h00, 1'b1);
        idle("post_r_done");
        chk("post_first", 32'(rdata), 32'hC3);

        // Randomized traffic with varying bias toward writes/reads
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            step("rand",
                 ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
                 8'($urandom),
                 ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))));
        end
        idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
